rgbw_scale_sequencer: RTL

RGBW_SCALE_SEQUENCER -- requirements
Module: rgbw_scale_sequencer

---
 rtl/rgbw_scale_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rgbw_scale_sequencer.sv
// Rescales four RGBW channel levels by a shared intensity through one external multiplier.
// Optional macro RGBW_SEQ_TIMEOUT_EN adds a WAIT timeout with a sticky err flag.
module rgbw_scale_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  lint,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic [7:0]  white_in,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  output logic        mult_ld,
  input  logic        mult_rdy,
  input  logic [15:0] mult_res,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic [7:0]  white_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StCommit} state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q;
  logic [7:0] lint_q;
  logic [7:0] snap_q   [4];
  logic [7:0] shadow_q [4];
  logic [7:0] out_q    [4];
  logic       done_q;
  logic       accept;
  logic       step;
  logic       timeout;
  logic       unused_res_lo;

  // Only the upper product byte is used: scaling truncates.
  assign unused_res_lo = ^mult_res[7:0];

  assign accept = (state_q == StIdle) && start;

`ifdef RGBW_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == StLoad) begin
      cnt_q <= '0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == StWait) && !mult_rdy &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign step = (state_q == StWait) && (mult_rdy || timeout);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StWait;
      StWait:   if (step) state_d = (idx_q == 2'd3) ? StCommit : StLoad;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= 2'd0;
      lint_q   <= 8'h00;
      snap_q   <= '{default: 8'h00};
      shadow_q <= '{default: 8'h00};
      out_q    <= '{default: 8'h00};
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        lint_q    <= lint;
        snap_q[0] <= red_in;
        snap_q[1] <= green_in;
        snap_q[2] <= blue_in;
        snap_q[3] <= white_in;
        idx_q     <= 2'd0;
      end
      if (step) begin
        shadow_q[idx_q] <= timeout ? 8'h00 : mult_res[15:8];
        idx_q           <= idx_q + 2'd1;
      end
      // All four outputs update together so the PWM never sees a mixed set.
      if (state_q == StCommit) begin
        out_q  <= shadow_q;
        done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    mult_ld = (state_q == StLoad);
    mult_a  = 8'h00;
    mult_b  = 8'h00;
    if ((state_q == StLoad) || (state_q == StWait)) begin
      mult_a = snap_q[idx_q];
      mult_b = lint_q;
    end
  end

  assign red_out   = out_q[0];
  assign green_out = out_q[1];
  assign blue_out  = out_q[2];
  assign white_out = out_q[3];
  assign done      = done_q;

endmodule
